// File: rtl/sw_lap_timer.sv
// ---------------------------------------------------------------------------
// sw_lap_timer
//   Stopwatch timing core with a circular lap-capture buffer. Counts
//   hour:min:sec:msec at TICK_HZ resolution and stores up to LAP_DEPTH lap
//   snapshots that can be browsed oldest-first.
//
// Parameters
//   CLK_FREQ_HZ : system clock frequency (Hz)
//   TICK_HZ     : sub-second count rate; CLK_FREQ_HZ / TICK_HZ integer >= 1
//   HOUR_MAX    : hour field wraps HOUR_MAX-1 -> 0 (1..32)
//   LAP_DEPTH   : lap entries, power of two, 2..64
//
// Ports
//   clk, rst     : clock, synchronous active-high reset
//   i_run        : level, 1 = counting, 0 = hold
//   i_clear      : pulse, zero time, divider and lap buffer
//   i_lap        : pulse, capture o_time into the lap buffer
//   i_lap_next   : pulse, advance browse index (modulo stored count)
//   o_time       : live time {hour[23:19], min[18:13], sec[12:7], msec[6:0]}
//   o_lap_time   : lap entry at browse index (0 when buffer empty)
//   o_lap_idx    : browse index, oldest entry = 0
//   o_lap_count  : number of stored laps
//   o_lap_full   : o_lap_count == LAP_DEPTH
//
// Build option
//   SW_LAP_OVERWRITE_EN : when defined, a lap into a full buffer overwrites
//                         the oldest entry; otherwise it is dropped.
// ---------------------------------------------------------------------------
module sw_lap_timer #(
   parameter int CLK_FREQ_HZ = 100_000_000,
   parameter int TICK_HZ     = 100,
   parameter int HOUR_MAX    = 24,
   parameter int LAP_DEPTH   = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_run,
   input  logic                         i_clear,
   input  logic                         i_lap,
   input  logic                         i_lap_next,
   output logic [23:0]                  o_time,
   output logic [23:0]                  o_lap_time,
   output logic [$clog2(LAP_DEPTH)-1:0] o_lap_idx,
   output logic [$clog2(LAP_DEPTH):0]   o_lap_count,
   output logic                         o_lap_full
);

   localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
   localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int PW  = $clog2(LAP_DEPTH);
   localparam int CW  = PW + 1;

   localparam logic [DW-1:0] DIV_LAST   = DW'(DIV - 1);
   // Rates above 100 Hz still display in a two-digit field: msec stops at 99.
   localparam logic [6:0]    MSEC_LAST  = (TICK_HZ > 100) ? 7'd99 : 7'(TICK_HZ - 1);
   localparam logic [4:0]    HOUR_LAST  = 5'(HOUR_MAX - 1);
   localparam logic [CW-1:0] COUNT_FULL = CW'(LAP_DEPTH);

`ifdef SW_LAP_OVERWRITE_EN
   localparam bit OVERWRITE = 1'b1;
`else
   localparam bit OVERWRITE = 1'b0;
`endif

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [DW-1:0] div_q;
   logic [4:0]    hour_q, hour_d;
   logic [5:0]    min_q,  min_d;
   logic [5:0]    sec_q,  sec_d;
   logic [6:0]    msec_q, msec_d;

   logic [23:0]   entry_q [LAP_DEPTH];
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] base_q;
   logic [CW-1:0] count_q;
   logic [PW-1:0] idx_q, idx_d;
   logic [23:0]   lap_time_q;

   logic          tick;
   logic          full;
   logic          lap_wr;
   logic [PW-1:0] rd_ptr;

   assign tick   = i_run && (div_q == DIV_LAST);
   assign full   = (count_q == COUNT_FULL);
   assign lap_wr = i_lap && (!full || OVERWRITE);
   // Power-of-two depth: pointer arithmetic wraps naturally.
   assign rd_ptr = base_q + idx_q;

   // ------------------------------------------------------------------
   // Time fields: the whole carry chain resolves within the tick cycle.
   // ------------------------------------------------------------------
   always_comb begin
      hour_d = hour_q;
      min_d  = min_q;
      sec_d  = sec_q;
      msec_d = msec_q;
      if (tick) begin
         if (msec_q == MSEC_LAST) begin
            msec_d = 7'd0;
            if (sec_q == 6'd59) begin
               sec_d = 6'd0;
               if (min_q == 6'd59) begin
                  min_d = 6'd0;
                  if (hour_q == HOUR_LAST) begin
                     hour_d = 5'd0;
                  end else begin
                     hour_d = hour_q + 5'd1;
                  end
               end else begin
                  min_d = min_q + 6'd1;
               end
            end else begin
               sec_d = sec_q + 6'd1;
            end
         end else begin
            msec_d = msec_q + 7'd1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Browse index: advances against the count held before this cycle's
   // capture, so a simultaneous lap does not widen the modulus yet.
   // A full-buffer overwrite keeps count at LAP_DEPTH, so idx stays legal.
   // ------------------------------------------------------------------
   always_comb begin
      idx_d = idx_q;
      if (i_lap_next && (count_q != '0)) begin
         if ((CW'(idx_q) + CW'(1)) == count_q) begin
            idx_d = '0;
         end else begin
            idx_d = idx_q + PW'(1);
         end
      end
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         div_q      <= '0;
         hour_q     <= '0;
         min_q      <= '0;
         sec_q      <= '0;
         msec_q     <= '0;
         wr_ptr_q   <= '0;
         base_q     <= '0;
         count_q    <= '0;
         idx_q      <= '0;
         lap_time_q <= '0;
      end else begin
         // Divider holds its value while stopped so a restart loses no tick.
         if (i_run) begin
            div_q <= (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
         end
         hour_q <= hour_d;
         min_q  <= min_d;
         sec_q  <= sec_d;
         msec_q <= msec_d;

         if (lap_wr) begin
            wr_ptr_q <= wr_ptr_q + PW'(1);
            if (full) begin
               base_q <= base_q + PW'(1);
            end else begin
               count_q <= count_q + CW'(1);
            end
         end

         idx_q      <= idx_d;
         lap_time_q <= (count_q == '0) ? 24'd0 : entry_q[rd_ptr];
      end
   end

   // Lap storage has no reset: entries are only visible below count_q.
   always_ff @(posedge clk) begin
      if (!rst && !i_clear && lap_wr) begin
         entry_q[wr_ptr_q] <= o_time;
      end
   end

   assign o_time      = {hour_q, min_q, sec_q, msec_q};
   assign o_lap_time  = lap_time_q;
   assign o_lap_idx   = idx_q;
   assign o_lap_count = count_q;
   assign o_lap_full  = full;

endmodule

// File: doc/sw_lap_timer.md
# sw_lap_timer

Parametrised stopwatch timing core with a lap-capture buffer. It is the next-generation stopwatch datapath for the stopwatch/watch top level. It counts time at a configurable resolution and hour range, and stores up to LAP_DEPTH lap snapshots in a circular buffer. The buffer can be browsed so the FND controller can show either the live time or a stored lap, using the existing packed 24-bit time word.

## Interface
Parameters:
- CLK_FREQ_HZ, 100_000_000, system clock frequency.
- TICK_HZ, 100, count rate of the sub-second field; CLK_FREQ_HZ / TICK_HZ must be an integer ≥ 1.
- HOUR_MAX, 24, hour field wraps at HOUR_MAX−1 → 0; legal range 1..32.
- LAP_DEPTH, 8, number of lap entries; power of two, 2..64.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- i_run  in  1  level; 1 = counting, 0 = hold.
- i_clear  in  1  one-cycle pulse; zero the time, divider and lap buffer.
- i_lap  in  1  one-cycle pulse; capture the current time into the lap buffer.
- i_lap_next  in  1  one-cycle pulse; advance the browse index.
- o_time  out  24  live time: {hour[23:19], min[18:13], sec[12:7], msec[6:0]}.
- o_lap_time  out  24  lap entry at the browse index, same packing.
- o_lap_idx  out  $clog2(LAP_DEPTH)  browse index, oldest entry = 0.
- o_lap_count  out  $clog2(LAP_DEPTH)+1  number of stored laps.
- o_lap_full  out  1  o_lap_count == LAP_DEPTH.

## Operation
- Divider counts 0..CLK_FREQ_HZ/TICK_HZ−1 while i_run=1; tick = terminal count. Divider freezes while i_run=0.
- Field wrap rules on tick:
  - msec wraps at TICK_HZ−1; if TICK_HZ > 100, msec saturates its 7-bit field at 99 and carries.
  - sec and min wrap at 59.
  - hour wraps at HOUR_MAX−1 → 0.
  - Each carry is combinational within the tick cycle.
- Lap buffer: circular buffer with write pointer, read base (oldest) and count.
  - i_lap when not full: write o_time to the write slot, increment count.
  - i_lap when full: dropped (see Configuration).
- Browse: o_lap_idx increments modulo o_lap_count on i_lap_next. It is ignored when count = 0. o_lap_time = entry[(base + idx) mod LAP_DEPTH]. When count = 0, o_lap_time = 0.
- i_clear: time = 0, divider = 0, count = 0, idx = 0, pointers = 0. Laps are not retained.
- Priority in the same cycle: i_clear > i_lap > i_lap_next > tick.
  - i_clear together with any other input: only the clear takes effect.
  - i_lap with a tick: captures the pre-increment value.
  - i_lap with i_lap_next: both apply; idx is computed against the old count.
- Laps are accepted while stopped.

## Timing
- Reset values: o_time = 0, o_lap_time = 0, o_lap_idx = 0, o_lap_count = 0, o_lap_full = 0, divider = 0.
- o_time is registered and changes the cycle after the tick cycle.
- Lap capture: o_lap_count/o_lap_full update 1 cycle after i_lap.
- o_lap_time is registered and reflects index/content changes 1 cycle after they occur, so 2 cycles after i_lap_next or i_lap.
- A clear or reset in mid-count takes effect at the next edge. No partial state remains.
- Rising i_run restarts counting from the held divider value, with no tick lost or doubled.

## Configuration
- SW_LAP_OVERWRITE_EN defined:
  - i_lap when full overwrites the oldest entry and advances the read base.
  - count stays LAP_DEPTH.
  - o_lap_idx is held unless it would exceed count−1.
- Undefined: i_lap when full is ignored and buffer contents are unchanged.
- o_lap_full behaves identically in both builds.

## Test plan
- Rollover: CLK_FREQ_HZ=TICK_HZ=100, HOUR_MAX=2, i_run=1 for 720,000 cycles from reset -> o_time passes 01:59:59.99 (hour 1, min 59, sec 59, msec 99) then reads 0x000000.
- Divider: CLK_FREQ_HZ=1000, TICK_HZ=100, i_run=1 for 25 cycles, drop for 7, raise for 5 -> msec = 3; at most one msec step per 10 running cycles.
- Lap capture/browse: capture at msec 5, 17 and 42 (LAP_DEPTH=4), then pulse i_lap_next ×3 -> o_lap_time msec sequence 5, 17, 42, 5; o_lap_count = 3.
- Full buffer: 5 laps into LAP_DEPTH=4 at msec 1..5 -> without the macro, entries 1..4 and o_lap_full=1; with SW_LAP_OVERWRITE_EN, entries 2..5 with idx 0 = msec 2.
- Simultaneous events: i_clear with i_lap on the tick cycle -> o_time = 0, o_lap_count = 0. i_lap on the tick cycle at msec 9 -> stored msec = 9.
- Reset mid-run: assert rst for 1 cycle with count = 3 and time = 00:00:01.23 -> all outputs 0 on the next cycle. Counting resumes from 0 after release, with i_run still high.
